// File: rtl/imem_boot_loader.sv
// Instruction memory port owner: boots code from a byte stream,
// then hands the single memory port over to core fetch.
module imem_boot_loader #(
   parameter  int MEM_SIZE   = 1024,
   parameter  int INST_WIDTH = 32,
   localparam int ADDR_W     = $clog2(MEM_SIZE) + 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_start_i,
   input  logic [ADDR_W-2:0]     load_len_i,
   input  logic                  run_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   output logic                  byte_ready_o,
   input  logic [ADDR_W-1:0]     fetch_addr_i,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [INST_WIDTH-1:0] mem_wdata_o,
   output logic                  mem_we_o,
   output logic                  core_hold_o,
   output logic                  load_done_o,
   output logic                  busy_o
);
   localparam int NB = INST_WIDTH / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int LW = ADDR_W - 1;
   localparam int IW = ADDR_W - 2;
   localparam logic [LW-1:0] LEN_MAX = LW'(MEM_SIZE);

   typedef enum logic [1:0] {HOLD, LOAD, WRITE, RUN} state_t;

   state_t                state;
   logic [CW-1:0]         byte_cnt;
   logic [IW-1:0]         word_idx;
   logic [LW-1:0]         len;
   logic [INST_WIDTH-1:0] wdata;
   logic                  done_q;
   logic [LW-1:0]         len_in;
   logic                  last_word;

   assign len_in    = (load_len_i > LEN_MAX) ? LEN_MAX : load_len_i;
   assign last_word = ({1'b0, word_idx} == len - LW'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= HOLD;
         byte_cnt <= '0;
         word_idx <= '0;
         len      <= '0;
         wdata    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            HOLD, RUN: begin
               if (load_start_i) begin
                  len      <= len_in;
                  word_idx <= '0;
                  byte_cnt <= '0;
                  if (len_in == '0) begin
                     state  <= RUN;
                     done_q <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end else if (run_i) begin
                  state <= RUN;
               end
            end
            LOAD: begin
               if (byte_valid_i) begin
                  for (int b = 0; b < NB; b++) begin
                     if (byte_cnt == CW'(b))
                        wdata[8*b +: 8] <= byte_data_i;
                  end
                  byte_cnt <= byte_cnt + CW'(1);
                  if (byte_cnt == CW'(NB - 1))
                     state <= WRITE;
               end
            end
            WRITE: begin
               if (last_word) begin
                  state  <= RUN;
                  done_q <= 1'b1;
               end else begin
                  word_idx <= word_idx + IW'(1);
                  state    <= LOAD;
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

   // Outside a load the port belongs to fetch, even while the core is held.
   assign busy_o       = (state == LOAD) || (state == WRITE);
   assign byte_ready_o = (state == LOAD);
   assign mem_we_o     = (state == WRITE);
   assign core_hold_o  = (state != RUN);
   assign load_done_o  = done_q;
   assign mem_wdata_o  = wdata;
   assign mem_addr_o   = busy_o ? {word_idx, 2'b00} : fetch_addr_i;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random byte streams against
// a word-level model of the expected memory writes.
module tb_imem_boot_loader;
   localparam int MS = 1024;
   localparam int AW = 12;
   localparam int LW = 11;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          load_start_i;
   logic [LW-1:0] load_len_i;
   logic          run_i;
   logic          byte_valid_i;
   logic [7:0]    byte_data_i;
   logic          byte_ready_o;
   logic [AW-1:0] fetch_addr_i;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic          mem_we_o;
   logic          core_hold_o;
   logic          load_done_o;
   logic          busy_o;

   int            checks = 0;
   int            fails  = 0;
   int            we_count = 0;
   logic [AW-1:0] last_we_addr = '0;
   logic [31:0]   stim[$];

   imem_boot_loader #(.MEM_SIZE(MS), .INST_WIDTH(32)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_start_i (load_start_i),
      .load_len_i   (load_len_i),
      .run_i        (run_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .fetch_addr_i (fetch_addr_i),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_we_o     (mem_we_o),
      .core_hold_o  (core_hold_o),
      .load_done_o  (load_done_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (mem_we_o === 1'b1) begin
         we_count     <= we_count + 1;
         last_we_addr <= mem_addr_o;
      end
   end

   task automatic idle_inputs();
      load_start_i = 1'b0;
      load_len_i   = '0;
      run_i        = 1'b0;
      byte_valid_i = 1'b0;
      byte_data_i  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   // Starts a load of len words and plays the bytes of each expected
   // word, predicting every handshake, write and completion cycle.
   task automatic run_load(input int len, input int gap_max,
                           input bit noise, input bit with_run);
      int          n;
      int          we0;
      int          gaps;
      logic [31:0] word;
      n   = (len > MS) ? MS : len;
      we0 = we_count;
      load_start_i = 1'b1;
      run_i        = with_run;
      load_len_i   = LW'(len);
      @(posedge clk_i); #1;
      load_start_i = 1'b0;
      run_i        = 1'b0;
      load_len_i   = LW'($urandom);
      for (int w = 0; w < n; w++) begin
         word = (w < stim.size()) ? stim[w] : $urandom;
         for (int b = 0; b < 4; b++) begin
            gaps = $urandom_range(0, gap_max);
            repeat (gaps) begin
               byte_valid_i = 1'b0;
               byte_data_i  = 8'($urandom);
               if (noise) begin
                  load_start_i = 1'($urandom);
                  run_i        = 1'($urandom);
               end
               checks++;
               if (byte_ready_o !== 1'b1 || busy_o !== 1'b1 ||
                   core_hold_o !== 1'b1 || mem_we_o !== 1'b0) begin
                  fails++;
                  $display("FAIL load_gap w%0d b%0d: rdy=%b busy=%b hold=%b we=%b want 1 1 1 0",
                           w, b, byte_ready_o, busy_o, core_hold_o, mem_we_o);
               end
               @(posedge clk_i); #1;
               load_start_i = 1'b0;
               run_i        = 1'b0;
            end
            byte_valid_i = 1'b1;
            byte_data_i  = word[8*b +: 8];
            checks++;
            if (byte_ready_o !== 1'b1 || mem_addr_o !== AW'(w * 4) ||
                core_hold_o !== 1'b1) begin
               fails++;
               $display("FAIL load_byte w%0d b%0d: rdy=%b addr=%h hold=%b want 1 %h 1",
                        w, b, byte_ready_o, mem_addr_o, core_hold_o, AW'(w * 4));
            end
            @(posedge clk_i); #1;
            byte_valid_i = 1'b0;
         end
         if (noise) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'($urandom);
         end
         checks++;
         if (mem_we_o !== 1'b1 || byte_ready_o !== 1'b0 ||
             mem_addr_o !== AW'(w * 4) || mem_wdata_o !== word) begin
            fails++;
            $display("FAIL write w%0d: we=%b rdy=%b addr=%h data=%h want 1 0 %h %h",
                     w, mem_we_o, byte_ready_o, mem_addr_o, mem_wdata_o,
                     AW'(w * 4), word);
         end
         @(posedge clk_i); #1;
         byte_valid_i = 1'b0;
      end
      checks++;
      if (load_done_o !== 1'b1 || core_hold_o !== 1'b0 || busy_o !== 1'b0 ||
          mem_we_o !== 1'b0 || (we_count - we0) !== n) begin
         fails++;
         $display("FAIL load_end len%0d: done=%b hold=%b busy=%b we=%b writes=%0d want 1 0 0 0 %0d",
                  len, load_done_o, core_hold_o, busy_o, mem_we_o,
                  we_count - we0, n);
      end
      @(posedge clk_i); #1;
      checks++;
      if (load_done_o !== 1'b0 || core_hold_o !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse len%0d: done=%b hold=%b want 0 0",
                  len, load_done_o, core_hold_o);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (core_hold_o !== 1'b1 || mem_we_o !== 1'b0 || byte_ready_o !== 1'b0 ||
          busy_o !== 1'b0 || load_done_o !== 1'b0 || mem_wdata_o !== 32'h0) begin
         fails++;
         $display("FAIL reset: hold=%b we=%b rdy=%b busy=%b done=%b data=%h want 1 0 0 0 0 0",
                  core_hold_o, mem_we_o, byte_ready_o, busy_o, load_done_o,
                  mem_wdata_o);
      end
      fetch_addr_i = AW'($urandom);
      #1;
      checks++;
      if (mem_addr_o !== fetch_addr_i) begin
         fails++;
         $display("FAIL hold_addr: got %h want %h", mem_addr_o, fetch_addr_i);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      stim = '{32'h0000_0013, 32'h0010_0093};
      run_load(2, 0, 1'b0, 1'b0);
      stim.delete();
   endtask

   task automatic test_gaps();
      do_reset();
      run_load(1, 3, 1'b1, 1'b0);
      repeat (3) run_load($urandom_range(1, 4), 3, 1'b1, 1'b0);
   endtask

   task automatic test_run();
      int we0;
      logic [AW-1:0] fa[2];
      fa[0] = 12'h010;
      fa[1] = 12'h014;
      do_reset();
      we0   = we_count;
      run_i = 1'b1;
      @(posedge clk_i); #1;
      run_i = 1'b0;
      checks++;
      if (core_hold_o !== 1'b0 || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
         fails++;
         $display("FAIL run_entry: hold=%b busy=%b rdy=%b want 0 0 0",
                  core_hold_o, busy_o, byte_ready_o);
      end
      for (int i = 0; i < 2; i++) begin
         fetch_addr_i = fa[i];
         byte_valid_i = 1'b1;
         byte_data_i  = 8'($urandom);
         #1;
         checks++;
         if (mem_addr_o !== fa[i] || byte_ready_o !== 1'b0 || mem_we_o !== 1'b0) begin
            fails++;
            $display("FAIL run_fetch %0d: addr=%h rdy=%b we=%b want %h 0 0",
                     i, mem_addr_o, byte_ready_o, mem_we_o, fa[i]);
         end
         @(posedge clk_i); #1;
      end
      byte_valid_i = 1'b0;
      checks++;
      if (we_count !== we0) begin
         fails++;
         $display("FAIL run_no_write: writes=%0d want 0", we_count - we0);
      end
      do_reset();
      run_load(1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midload();
      do_reset();
      load_start_i = 1'b1;
      load_len_i   = 11'd2;
      @(posedge clk_i); #1;
      load_start_i = 1'b0;
      byte_valid_i = 1'b1;
      byte_data_i  = 8'hAA;
      @(posedge clk_i); #1;
      byte_data_i  = 8'hBB;
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      checks++;
      if (core_hold_o !== 1'b1 || busy_o !== 1'b0 || byte_ready_o !== 1'b0 ||
          mem_we_o !== 1'b0) begin
         fails++;
         $display("FAIL midload_reset: hold=%b busy=%b rdy=%b we=%b want 1 0 0 0",
                  core_hold_o, busy_o, byte_ready_o, mem_we_o);
      end
      stim = '{32'h1234_5678};
      run_load(1, 1, 1'b0, 1'b0);
      stim.delete();
   endtask

   task automatic test_len_edges();
      do_reset();
      run_load(0, 0, 1'b0, 1'b0);
      do_reset();
      run_load(MS + 5, 0, 1'b0, 1'b0);
      checks++;
      if (last_we_addr !== AW'((MS - 1) * 4)) begin
         fails++;
         $display("FAIL clamp_last_addr: got %h want %h",
                  last_we_addr, AW'((MS - 1) * 4));
      end
   endtask

   task automatic test_back_to_back_loads();
      int len;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
         run_load(len, 2, 1'b1, 1'($urandom));
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      fetch_addr_i = '0;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_gaps();
      test_run();
      test_reset_midload();
      test_len_edges();
      test_back_to_back_loads();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
